// File: rtl/memory_responder.sv
// Responder end of the core memory request protocol: arbitrates instruction and data
// requests onto one shared RAM port and returns single-cycle hit pulses after LAT cycles.
module memory_responder #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
);

    localparam int unsigned   DATA_W   = 32;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                req_live;
    logic                done;

    // Originating request of the access in flight; low in IDLE.
    always_comb begin
        req_live = 1'b0;
        case (state_q)
            IBUSY:   req_live = iREN;
            DBUSY:   req_live = dREN | dWEN;
            default: req_live = 1'b0;
        endcase
        done = req_live && (cnt_q == '0);
    end

    // State and latched-request registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state: data wins over instruction at every IDLE; a dropped request aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    state_d = DBUSY;
                    addr_d  = daddr;
                    wdata_d = dstore;
                    wr_d    = dWEN;
                    cnt_d   = CNT_INIT;
                end else if (iREN) begin
                    state_d = IBUSY;
                    addr_d  = iaddr;
                    wr_d    = 1'b0;
                    cnt_d   = CNT_INIT;
                end
            end
            IBUSY, DBUSY: begin
                if (!req_live || done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM strobes follow the live request so an abort drops them in the same cycle.
    always_comb begin
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IBUSY: begin
                ramaddr  = addr_q;
                ramstore = wdata_q;
                ramREN   = req_live;
                ihit     = done;
                iload    = done ? ramload : '0;
            end
            DBUSY: begin
                ramaddr  = addr_q;
                ramstore = wdata_q;
                ramREN   = req_live && !wr_q;
                ramWEN   = req_live && wr_q;
                dhit     = done;
                dload    = done ? ramload : '0;
            end
            default: ;
        endcase
    end

endmodule
